// File: rtl/dm_latency_ctrl_pkg.sv
// dm_pkg: size codes and FSM state encoding shared by the data memory block.
package dm_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
endpackage

// File: rtl/dm_latency_ctrl_if.sv
// dm_latency_ctrl_if: request/response bus between the MEM stage and the data memory.
interface dm_latency_ctrl_if;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_err, init_done;
  logic [31:0] resp_rdata;
  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_done
  );
  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err, init_done
  );
endinterface

// File: rtl/dm_latency_ctrl_lane.sv
// dm_lane_unit: store lane merge and load lane extract with sign/zero extension.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    merged_word = old_word;
    if (size == SZ_B) merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_H) merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else if (size == SZ_W) merged_word = wdata;
  end
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    load_data = size == SZ_B ? {{24{sext & b[7]}}, b} :
                size == SZ_H ? {{16{sext & h[15]}}, h} : word;
  end
endmodule

// File: rtl/dm_latency_ctrl.sv
// dm_latency_ctrl: data memory with req/resp handshake, fixed access latency,
// byte/half/word lanes, alignment/range faults and a post-reset clear sweep.
module dm_latency_ctrl
  import dm_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter bit          LOG_EN    = 1
) (
  input logic clk,
  input logic reset,
  dm_latency_ctrl_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [CW-1:0]     cnt;
  logic              r_we, r_sext, err, commit, accept;
  logic [1:0]        r_size;
  logic [31:0]       r_addr, r_wdata, r_pc, off, old_word, merged_word, load_data;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       mem [2**ADDR_W];
  assign bus.req_ready  = state == ST_IDLE || state == ST_RESP;
  assign bus.resp_valid = state == ST_RESP;
  assign accept   = bus.req_valid && bus.req_ready;
  assign commit   = state == ST_BUSY && cnt == '0;
  assign off      = r_addr - BASE_ADDR;
  assign widx     = off[ADDR_W+1:2];
  assign old_word = mem[widx];
  // below-base addresses wrap to huge offsets and fall into the range fault
  assign err = r_size == 2'd3 || (r_size == SZ_H && r_addr[0]) ||
               (r_size == SZ_W && r_addr[1:0] != 2'b00) || off[31:ADDR_W+2] != '0;
  dm_lane_unit u_lane (
    .old_word(old_word), .wdata(r_wdata), .word(old_word), .size(r_size),
    .lane(r_addr[1:0]), .sext(r_sext), .merged_word(merged_word), .load_data(load_data)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      idx <= '0;
      cnt <= '0;
      {r_we, r_sext, r_size, r_addr, r_wdata, r_pc} <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err <= 1'b0;
      bus.init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      idx <= idx + 1'b1;
      if (&idx) begin
        state <= ST_IDLE;
        bus.init_done <= 1'b1;
      end
    end else if (accept) begin
      {r_we, r_sext, r_size} <= {bus.req_we, bus.req_sext, bus.req_size};
      {r_addr, r_wdata, r_pc} <= {bus.req_addr, bus.req_wdata, bus.req_pc};
      cnt <= CW'(LATENCY - 1);
      state <= ST_BUSY;
    end else if (state == ST_BUSY) begin
      cnt <= cnt - 1'b1;
      if (commit) begin
        bus.resp_rdata <= (err || r_we) ? 32'h0 : load_data;
        bus.resp_err <= err;
        state <= ST_RESP;
      end
    end else if (state == ST_RESP) state <= ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[idx] <= '0;
    else if (commit && r_we && !err) begin
      mem[widx] <= merged_word;
      if (LOG_EN) $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, merged_word);
    end
  end
endmodule

// File: tb/tb_dm_latency_ctrl.sv
// tb_dm_latency_ctrl: directed checks of the latency data memory (L=3 main, L=1 throughput).
module tb_dm_latency_ctrl;
  logic clk = 0, reset = 1;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] rd;
  logic e;
  int lat;
  dm_latency_ctrl_if ifc ();
  dm_latency_ctrl_if ifc1 ();
  dm_latency_ctrl #(.ADDR_W(4), .LATENCY(3), .BASE_ADDR(32'h0), .LOG_EN(1)) dut (
    .clk(clk), .reset(reset), .bus(ifc));
  dm_latency_ctrl #(.ADDR_W(4), .LATENCY(1), .BASE_ADDR(32'h0), .LOG_EN(0)) dut1 (
    .clk(clk), .reset(reset), .bus(ifc1));
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    ifc.req_valid = 1; ifc.req_we = we; ifc.req_size = sz; ifc.req_sext = sx;
    ifc.req_addr = a; ifc.req_wdata = wd; ifc.req_pc = 32'h1000 + a;
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output logic er, output int l);
    int n = 0;
    drive(we, sz, sx, a, wd);
    while (!ifc.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ifc.req_valid = 0;
    l = 0;
    while (!ifc.resp_valid && l < 20) begin @(posedge clk); #1; l++; end
    r = ifc.resp_rdata; er = ifc.resp_err;
  endtask

  task automatic test_reset();
    bit bad = 0;
    n_cmp++;
    if (ifc.req_ready !== 1'b0 || ifc.init_done !== 1'b0 || ifc.resp_valid !== 1'b0 ||
        ifc.resp_rdata !== 32'h0 || ifc.resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b done=%b rv=%b rd=%h err=%b want all 0",
        ifc.req_ready, ifc.init_done, ifc.resp_valid, ifc.resp_rdata, ifc.resp_err);
    end
    drive(0, 2'd2, 0, 32'h0, 32'h0);
    @(posedge clk); #1; reset = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (ifc.init_done !== 1'b0 || ifc.req_ready !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL init_early: done/ready rose before 16 edges, want 0"); end
    @(posedge clk); #1;
    n_cmp++;
    if (ifc.init_done !== 1'b1 || ifc.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL init_16: done=%b ready=%b want 1 1", ifc.init_done, ifc.req_ready);
    end
    for (int w = 0; w < 16; w++) begin
      xfer(0, 2'd2, 0, 32'(w * 4), 32'h0, rd, e, lat);
      n_cmp++;
      if (rd !== 32'h0 || e !== 1'b0) begin
        n_fail++; $display("FAIL init_word%0d: rd=%h err=%b want 00000000 0", w, rd, e);
      end
    end
  endtask

  task automatic test_word();
    xfer(1, 2'd2, 0, 32'h8, 32'h11223344, rd, e, lat);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
      n_fail++; $display("FAIL sw_lat: lat=%0d rd=%h err=%b want 3 00000000 0", lat, rd, e);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ifc.resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_pulse: rv=%b want 0", ifc.resp_valid); end
    xfer(0, 2'd2, 0, 32'h8, 32'h0, rd, e, lat);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h11223344 || e !== 1'b0) begin
      n_fail++; $display("FAIL lw_8: lat=%0d rd=%h err=%b want 3 11223344 0", lat, rd, e);
    end
  endtask

  task automatic test_lanes();
    xfer(1, 2'd0, 0, 32'h9, 32'hCDEF01AB, rd, e, lat);
    xfer(0, 2'd0, 1, 32'h9, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'hFFFFFFAB || e !== 1'b0) begin n_fail++; $display("FAIL lb_sext: rd=%h want FFFFFFAB", rd); end
    xfer(0, 2'd0, 0, 32'h9, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL lbu: rd=%h want 000000AB", rd); end
    xfer(0, 2'd1, 1, 32'h8, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'hFFFFAB44) begin n_fail++; $display("FAIL lh_sext: rd=%h want FFFFAB44", rd); end
    xfer(0, 2'd1, 0, 32'hA, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h00001122) begin n_fail++; $display("FAIL lhu_hi: rd=%h want 00001122", rd); end
    xfer(1, 2'd1, 0, 32'h6, 32'hFFFF8765, rd, e, lat);
    xfer(0, 2'd2, 0, 32'h4, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h87650000) begin n_fail++; $display("FAIL sh_hi: rd=%h want 87650000", rd); end
    xfer(0, 2'd2, 0, 32'h8, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL lw_merged: rd=%h want 1122AB44", rd); end
  endtask

  task automatic test_errors();
    xfer(1, 2'd1, 0, 32'h9, 32'h5555, rd, e, lat);
    n_cmp++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      n_fail++; $display("FAIL err_sh_mis: err=%b rd=%h lat=%0d want 1 0 3", e, rd, lat);
    end
    xfer(0, 2'd2, 0, 32'hA, 32'h0, rd, e, lat);
    n_cmp++;
    if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lw_mis: err=%b rd=%h want 1 0", e, rd); end
    xfer(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, rd, e, lat);
    n_cmp++;
    if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_range: err=%b rd=%h want 1 0", e, rd); end
    xfer(0, 2'd3, 0, 32'h0, 32'h0, rd, e, lat);
    n_cmp++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL err_size3: err=%b want 1", e); end
    xfer(0, 2'd2, 0, 32'h8, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h1122AB44 || e !== 1'b0) begin n_fail++; $display("FAIL err_nowrite8: rd=%h want 1122AB44", rd); end
    xfer(0, 2'd2, 0, 32'h0, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL err_nowrite0: rd=%h want 00000000", rd); end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    int n = 0;
    drive(1, 2'd2, 0, 32'h4, 32'hCAFEF00D);
    while (!ifc.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; ifc.req_valid = 0;
    @(posedge clk); #1; reset = 1; #1;
    n_cmp++;
    if (ifc.resp_valid !== 1'b0 || ifc.init_done !== 1'b0 || ifc.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: rv=%b done=%b ready=%b want 0 0 0", ifc.resp_valid, ifc.init_done, ifc.req_ready);
    end
    @(posedge clk); #1; reset = 0;
    n = 0;
    while (!ifc.init_done && n < 40) begin
      @(posedge clk); #1; n++;
      if (ifc.resp_valid) bad = 1;
    end
    n_cmp++;
    if (bad || ifc.init_done !== 1'b1) begin
      n_fail++; $display("FAIL mid_reinit: stray_resp=%b done=%b want 0 1", bad, ifc.init_done);
    end
    xfer(0, 2'd2, 0, 32'h4, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL mid_nowrite: rd=%h want 00000000", rd); end
    xfer(0, 2'd2, 0, 32'h8, 32'h0, rd, e, lat);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_swept: rd=%h want 00000000", rd); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, n = 0;
    bit bad = 0, prev = 0;
    while (!ifc1.init_done && n < 40) begin @(posedge clk); #1; n++; end
    ifc1.req_valid = 1; ifc1.req_we = 0; ifc1.req_size = 2'd2; ifc1.req_sext = 0;
    ifc1.req_addr = 32'h0; ifc1.req_wdata = 0; ifc1.req_pc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ifc1.resp_valid) begin
        pulses++;
        if (prev || ifc1.req_ready !== 1'b1) bad = 1;
      end
      prev = ifc1.resp_valid;
    end
    ifc1.req_valid = 0;
    n_cmp++;
    if (pulses !== 5 || bad) begin
      n_fail++; $display("FAIL b2b_l1: pulses=%0d irregular=%b want 5 0", pulses, bad);
    end
  endtask

  initial begin
    ifc.req_valid = 0; ifc.req_we = 0; ifc.req_size = 0; ifc.req_sext = 0;
    ifc.req_addr = 0; ifc.req_wdata = 0; ifc.req_pc = 0;
    ifc1.req_valid = 0; ifc1.req_we = 0; ifc1.req_size = 0; ifc1.req_sext = 0;
    ifc1.req_addr = 0; ifc1.req_wdata = 0; ifc1.req_pc = 0;
    #1;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
